// File: rtl/lifo_stack_if.sv
// Bundle of stack control, data and status signals shared by the
// lifo_stack core (slave side) and whatever drives it (master side).
interface lifo_stack_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              push;
  logic              pop;
  logic              flush;
  logic              clr_err;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;
  logic [CNT_W-1:0]  high_water;

  modport master (
    output push, pop, flush, clr_err, wdata,
    input  rdata, count, full, empty, overflow, underflow, high_water
  );

  modport slave (
    input  push, pop, flush, clr_err, wdata,
    output rdata, count, full, empty, overflow, underflow, high_water
  );
endinterface

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack: push/pop/replace-top, flush, sticky
// overflow/underflow flags and a high-water mark of the fill count.
// The interface instance must use the same DATA_W/DEPTH as this module.
module lifo_stack #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic         clk,
  input  logic         rst,
  lifo_stack_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  hw_q, hw_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              ovf_ev, udf_ev;
  logic              full, empty;
  logic              wr_en;
  logic [AW-1:0]     top_addr, wr_addr;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  // count never exceeds DEPTH, so count-1 always fits the address width
  assign top_addr = AW'(count_q - CNT_W'(1));

  // Replace-top writes at count-1; a plain push (or push+pop on empty) at count
  assign wr_addr  = (bus.pop && !empty) ? top_addr : AW'(count_q);
  assign wr_en    = !rst && !bus.flush && bus.push && (bus.pop || !full);

  // Next count, error events and high-water mark for the coming edge
  always_comb begin
    count_d = count_q;
    ovf_ev  = 1'b0;
    udf_ev  = 1'b0;
    if (bus.flush) begin
      count_d = '0;
    end else if (bus.push && bus.pop) begin
      if (empty) begin
        count_d = count_q + CNT_W'(1);
        udf_ev  = 1'b1;
      end
    end else if (bus.push) begin
      if (full) ovf_ev  = 1'b1;
      else      count_d = count_q + CNT_W'(1);
    end else if (bus.pop) begin
      if (empty) udf_ev  = 1'b1;
      else       count_d = count_q - CNT_W'(1);
    end
    ovf_d = ovf_ev | (ovf_q & ~bus.clr_err);
    udf_d = udf_ev | (udf_q & ~bus.clr_err);
    if (bus.flush)          hw_d = '0;
    else if (count_d > hw_q) hw_d = count_d;
    else                    hw_d = hw_q;
  end

  // Control/status state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      hw_q    <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      hw_q    <= hw_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Stack storage; contents are never reset, only hidden by count
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= bus.wdata;
  end

  assign bus.rdata      = empty ? '0 : mem_q[top_addr];
  assign bus.count      = count_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = udf_q;
  assign bus.high_water = hw_q;
endmodule

// File: tb/tb_lifo_stack.sv
// Bench for lifo_stack: drives a default-size and a small non-power-of-2
// instance with identical stimulus and compares both against a queue model.
module tb_lifo_stack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lifo_stack_if #(.DATA_W(32), .DEPTH(1024)) ifb ();
  lifo_stack_if #(.DATA_W(8),  .DEPTH(5))    ifs ();

  lifo_stack #(.DATA_W(32), .DEPTH(1024)) u_big (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  lifo_stack #(.DATA_W(8), .DEPTH(5)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (ifs.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per instance, back of queue is the top
  logic [31:0] mq [2][$];
  int          mdepth [2] = '{1024, 5};
  logic [31:0] mmask  [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
  bit          mov [2];
  bit          mun [2];
  int          mhw [2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input bit r, input bit f, input bit pu,
                            input bit po, input bit c, input logic [31:0] wd);
    bit oe, ue;
    int sz;
    oe = 1'b0;
    ue = 1'b0;
    if (r) begin
      mq[k].delete();
      mov[k] = 1'b0;
      mun[k] = 1'b0;
      mhw[k] = 0;
    end else begin
      if (f) begin
        mq[k].delete();
      end else if (pu && po) begin
        if (mq[k].size() == 0) begin
          mq[k].push_back(wd & mmask[k]);
          ue = 1'b1;
        end else begin
          mq[k][mq[k].size()-1] = wd & mmask[k];
        end
      end else if (pu) begin
        if (mq[k].size() == mdepth[k]) oe = 1'b1;
        else mq[k].push_back(wd & mmask[k]);
      end else if (po) begin
        if (mq[k].size() == 0) ue = 1'b1;
        else void'(mq[k].pop_back());
      end
      mov[k] = oe || (mov[k] && !c);
      mun[k] = ue || (mun[k] && !c);
      sz = mq[k].size();
      if (f) mhw[k] = 0;
      else if (sz > mhw[k]) mhw[k] = sz;
    end
  endtask

  task automatic compare_dut(input int k);
    logic [31:0] g_rd, e_rd;
    int g_cnt, g_hw, sz;
    bit g_full, g_empty, g_ov, g_un;
    string p;
    if (k == 0) begin
      p = "big"; g_rd = ifb.rdata; g_cnt = int'(ifb.count); g_hw = int'(ifb.high_water);
      g_full = ifb.full; g_empty = ifb.empty; g_ov = ifb.overflow; g_un = ifb.underflow;
    end else begin
      p = "small"; g_rd = {24'd0, ifs.rdata}; g_cnt = int'(ifs.count); g_hw = int'(ifs.high_water);
      g_full = ifs.full; g_empty = ifs.empty; g_ov = ifs.overflow; g_un = ifs.underflow;
    end
    sz   = mq[k].size();
    e_rd = (sz == 0) ? 32'd0 : mq[k][sz-1];
    check_eq({p, ".rdata"},      64'(g_rd),    64'(e_rd));
    check_eq({p, ".count"},      64'(g_cnt),   64'(sz));
    check_eq({p, ".full"},       64'(g_full),  64'(sz == mdepth[k]));
    check_eq({p, ".empty"},      64'(g_empty), 64'(sz == 0));
    check_eq({p, ".overflow"},   64'(g_ov),    64'(mov[k]));
    check_eq({p, ".underflow"},  64'(g_un),    64'(mun[k]));
    check_eq({p, ".high_water"}, 64'(g_hw),    64'(mhw[k]));
  endtask

  // One clock: drive inputs, let the edge happen, advance model, sample at negedge
  task automatic cycle(input bit r, input bit f, input bit pu, input bit po,
                       input bit c, input logic [31:0] wd);
    rst         = r;
    ifb.flush   = f;  ifs.flush   = f;
    ifb.push    = pu; ifs.push    = pu;
    ifb.pop     = po; ifs.pop     = po;
    ifb.clr_err = c;  ifs.clr_err = c;
    ifb.wdata   = wd; ifs.wdata   = wd[7:0];
    @(posedge clk);
    model_step(0, r, f, pu, po, c, wd);
    model_step(1, r, f, pu, po, c, wd);
    @(negedge clk);
    compare_dut(0);
    compare_dut(1);
  endtask

  task automatic do_reset();  cycle(1, 0, 0, 0, 0, 0);  endtask
  task automatic do_push(input logic [31:0] d);  cycle(0, 0, 1, 0, 0, d);  endtask
  task automatic do_pop();  cycle(0, 0, 0, 1, 0, 0);  endtask

  initial begin
    int p_push, p_pop, r;
    bit rr, ff, pu, po, cc;

    ifb.push = 0; ifb.pop = 0; ifb.flush = 0; ifb.clr_err = 0; ifb.wdata = '0;
    ifs.push = 0; ifs.pop = 0; ifs.flush = 0; ifs.clr_err = 0; ifs.wdata = '0;

    // Reset values
    do_reset();
    check_eq("small.reset_empty", 64'(ifs.empty), 64'd1);

    // Basic stacking A, B, C then unwind
    do_push(32'hA); do_push(32'hB); do_push(32'hC);
    check_eq("small.abc_top", 64'(ifs.rdata), 64'hC);
    check_eq("small.abc_hw",  64'(ifs.high_water), 64'd3);
    do_pop(); do_pop(); do_pop();
    check_eq("big.abc_hw_kept", 64'(ifb.high_water), 64'd3);

    // Fill past DEPTH (data = index), then unwind past empty
    for (int i = 0; i <= 1024; i++) begin
      do_push(32'(i));
      if (i == 5) begin
        check_eq("small.full_cnt", 64'(ifs.count), 64'd5);
        check_eq("small.full_top", 64'(ifs.rdata), 64'd4);
        check_eq("small.full_ovf", 64'(ifs.overflow), 64'd1);
      end
    end
    do_push(32'hDEAD);
    check_eq("big.full_top", 64'(ifb.rdata), 64'd1023);
    check_eq("big.full_ovf", 64'(ifb.overflow), 64'd1);
    for (int i = 0; i < 1026; i++) do_pop();
    check_eq("big.extra_pop_udf", 64'(ifb.underflow), 64'd1);

    // Replace-top at count 2, at full, and on empty
    do_reset();
    do_push(32'h3); do_push(32'h5);
    cycle(0, 0, 1, 1, 0, 32'h7);
    check_eq("small.repl_cnt", 64'(ifs.count), 64'd2);
    check_eq("small.repl_top", 64'(ifs.rdata), 64'h7);
    do_push(32'h21); do_push(32'h22); do_push(32'h23);
    cycle(0, 0, 1, 1, 0, 32'h11);
    check_eq("small.repl_full_top", 64'(ifs.rdata), 64'h11);
    check_eq("small.repl_full_ovf", 64'(ifs.overflow), 64'd0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 32'h9);
    check_eq("small.repl_empty_top", 64'(ifs.rdata), 64'h9);
    check_eq("small.repl_empty_udf", 64'(ifs.underflow), 64'd1);

    // clr_err alone, then clr_err racing a new overflow
    do_reset();
    for (int i = 0; i < 6; i++) do_push(32'(i + 1));
    cycle(0, 0, 0, 0, 1, 0);
    check_eq("small.clr_ovf", 64'(ifs.overflow), 64'd0);
    cycle(0, 0, 1, 0, 1, 32'h44);
    check_eq("small.clr_vs_ovf", 64'(ifs.overflow), 64'd1);

    // Flush with push at count 5; reset with push at count 3
    do_reset();
    for (int i = 0; i < 5; i++) do_push(32'(i + 16));
    cycle(0, 1, 1, 0, 0, 32'h77);
    check_eq("big.flush_hw", 64'(ifb.high_water), 64'd0);
    for (int i = 0; i < 3; i++) do_push(32'(i + 32));
    cycle(1, 0, 1, 0, 0, 32'h88);
    check_eq("big.rst_cnt", 64'(ifb.count), 64'd0);

    // Randomized traffic with phase-varying push/pop bias
    p_push = 50;
    p_pop  = 40;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) begin
        p_push = $urandom_range(15, 85);
        p_pop  = $urandom_range(15, 85);
      end
      r  = $urandom_range(0, 999);
      rr = (r < 3);
      ff = (r >= 3 && r < 10);
      pu = ($urandom_range(0, 99) < p_push);
      po = ($urandom_range(0, 99) < p_pop);
      cc = ($urandom_range(0, 99) < 4);
      cycle(rr, ff, pu, po, cc, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parametrised LIFO stack replacing the fixed 32x1024 push/pop stack used by the PUSH/POP instructions and the call/return path. Adds configurable width and depth, a fill count, simultaneous push+pop (replace-top), flush, sticky overflow/underflow error flags and a high-water mark for firmware stack-depth profiling. Single clock domain. Sits beside the register file in the CPU datapath.

## Interface
- DATA_W, 32, data word width in bits (>=1)
- DEPTH, 1024, number of entries (>=2, need not be a power of 2)
- CNT_W, $clog2(DEPTH+1), derived; width of count and high-water outputs; not overridden
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- push  in  1  write wdata onto stack
- pop  in  1  remove top entry
- flush  in  1  discard all entries (count -> 0)
- clr_err  in  1  clear sticky overflow/underflow flags
- wdata  in  DATA_W  data to push
- rdata  out  DATA_W  current top of stack; 0 when empty
- count  out  CNT_W  number of valid entries, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: push rejected while full
- underflow  out  1  sticky: pop rejected while empty
- high_water  out  CNT_W  maximum count reached since reset/flush

## Operation
- Storage: DEPTH x DATA_W memory indexed by pointer sp = count; top entry at mem[count-1].
- rdata = mem[count-1] when count>0, else 0; combinational from count, reflects state after the most recent edge.
- Priority per edge: rst > flush > push/pop.
- flush: count <- 0, high_water <- 0; push/pop that cycle ignored; error flags unchanged (unless clr_err).
- push only, not full: mem[count] <- wdata, count+1.
- push only, full: no write, count unchanged, overflow <- 1.
- pop only, not empty: count-1; memory not modified.
- pop only, empty: count unchanged, underflow <- 1.
- push & pop, not empty (including full): replace top: mem[count-1] <- wdata, count unchanged, no error.
- push & pop, empty: treated as push only (count -> 1, rdata = wdata); underflow <- 1.
- clr_err: overflow, underflow <- 0 that edge; a new error event in the same cycle wins (flag stays 1).
- high_water <- max(high_water, next count) each edge.
- Count arithmetic is CNT_W unsigned; never wraps (guarded by full/empty).
- Memory contents not reset; unreadable while count excludes them.

## Timing
- Reset (synchronous, rst high at rising edge): count=0, empty=1, full=0, overflow=0, underflow=0, high_water=0, rdata=0. Reset mid-operation drops any push/pop that cycle.
- Push latency 1 cycle: wdata visible on rdata after the edge that accepts it.
- Pop latency 1 cycle: new top on rdata after the edge.
- full/empty/count update on the same edge as the operation; combinational from count, no extra delay.
- No handshake/ready: caller gates push/pop with full/empty; violations only set flags.
- Back-to-back operations every cycle supported with no bubbles.

## Test plan
- Reset then push 0xA, 0xB, 0xC on consecutive cycles -> rdata 0xA, 0xB, 0xC after each edge; count=3, high_water=3; three pops -> rdata 0xB, 0xA, 0, empty=1, high_water stays 3.
- Fill to DEPTH (data = index), push 0xDEAD -> full=1, overflow=1, count=DEPTH, rdata=DEPTH-1; pop down to empty checks LIFO order for all entries; extra pop -> underflow=1, count=0.
- push&pop with count=2, top=0x5, wdata=0x7 -> count=2, rdata=0x7; same at full -> top replaced, overflow stays 0; push&pop when empty with wdata=0x9 -> count=1, rdata=0x9, underflow=1.
- Set overflow, assert clr_err alone -> overflow=0; clr_err together with push at full -> overflow remains 1.
- Count=5, assert flush with push -> count=0, empty=1, high_water=0, rdata=0, push dropped; assert rst with push at count=3 -> all outputs at reset values next cycle.
- Rerun stacking/boundary cases with DATA_W=8, DEPTH=5 (non-power-of-2): full at count=5, CNT_W=3, no wrap.
